// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and access-size decode for the load/store unit
package lsu_pkg;
  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_D  = 3'b011;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;
  localparam logic [2:0] LSU_F3_WU = 3'b110;
  typedef enum logic [2:0] {IDLE, B0_REQ, B0_WAIT, B1_REQ, B1_WAIT, DONE} lsu_state_t;
  function automatic logic [3:0] lsu_size(input logic [2:0] f3, input logic wide);
    return (f3 == LSU_F3_B || f3 == LSU_F3_BU) ? 4'd1 :
           (f3 == LSU_F3_H || f3 == LSU_F3_HU) ? 4'd2 :
           (f3 == LSU_F3_W)                    ? 4'd4 :
           (f3 == LSU_F3_WU && wide)           ? 4'd4 :
           (f3 == LSU_F3_D && wide)            ? 4'd8 : 4'd0;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables and store lanes for both beats (off, size, wdata -> be0/be1, wdata0/wdata1); load merge of lo/hi words with sign/zero extension (-> rdata)
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [3:0]                size,
  input  logic                      sext,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           lo,
  input  logic [XLEN-1:0]           hi,
  output logic [XLEN/8-1:0]         be0,
  output logic [XLEN/8-1:0]         be1,
  output logic [XLEN-1:0]           wdata0,
  output logic [XLEN-1:0]           wdata1,
  output logic [XLEN-1:0]           rdata
);
  localparam int NB = XLEN / 8;
  logic [2*NB-1:0]   be_w;
  logic [2*XLEN-1:0] wd_w;
  logic [2*XLEN-1:0] rd_w;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   keep;
  logic [XLEN-1:0]   msb;
  always_comb begin
    be_w  = (((2*NB)'(1) << size) - (2*NB)'(1)) << off;
    wd_w  = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    rd_w  = {hi, lo} >> {off, 3'b000};
    raw   = rd_w[XLEN-1:0];
    keep  = size >= 4'(NB) ? '1 : ~({XLEN{1'b1}} << {size, 3'b000});
    msb   = keep & ~(keep >> 1);
    rdata = (raw & keep) | ((sext && |(raw & msb)) ? ~keep : '0);
  end
  assign be0    = be_w[NB-1:0];
  assign be1    = be_w[2*NB-1:NB];
  assign wdata0 = wd_w[XLEN-1:0];
  assign wdata1 = wd_w[2*XLEN-1:XLEN];
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle LSU; core req_* valid/ready in, rsp_* one-cycle pulse out, word-aligned mem_* bus with byte enables
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int MISALIGNED_SPLIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              write_q, write_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic              fault_q, fault_d;
  logic [3:0]        size_q, req_size;
  logic              cross_q, req_cross, req_bad, beat1;
  logic [NB-1:0]     be0, be1;
  logic [XLEN-1:0]   wdata0, wdata1, ld_data;
  logic [ADDR_W-1:0] aligned;
  assign size_q    = lsu_size(f3_q, XLEN == 64);
  assign req_size  = lsu_size(req_funct3, XLEN == 64);
  assign cross_q   = 5'(addr_q[OB-1:0]) + 5'(size_q) > 5'(NB);
  assign req_cross = 5'(req_addr[OB-1:0]) + 5'(req_size) > 5'(NB);
  assign req_bad   = req_size == 4'd0 || (req_write && req_funct3[2]) || (req_cross && MISALIGNED_SPLIT == 0);
  lsu_align #(.XLEN(XLEN)) u_align (
    .off(addr_q[OB-1:0]), .size(size_q), .sext(!f3_q[2]), .wdata(wdata_q),
    .lo(lo_q), .hi(hi_q), .be0(be0), .be1(be1), .wdata0(wdata0), .wdata1(wdata1), .rdata(ld_data)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    write_d = write_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = req_addr;
        f3_d    = req_funct3;
        write_d = req_write;
        wdata_d = req_wdata;
        lo_d    = '0;
        hi_d    = '0;
        fault_d = req_bad;
        state_d = B0_REQ;
      end
      B0_REQ:  state_d = fault_q ? DONE : mem_req_ready ? B0_WAIT : B0_REQ;
      B0_WAIT: if (mem_rsp_valid) begin
        lo_d    = mem_rsp_rdata;
        fault_d = mem_rsp_err;
        state_d = (mem_rsp_err || !cross_q) ? DONE : B1_REQ;
      end
      B1_REQ:  state_d = mem_req_ready ? B1_WAIT : B1_REQ;
      B1_WAIT: if (mem_rsp_valid) begin
        hi_d    = mem_rsp_rdata;
        fault_d = mem_rsp_err;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      fault_q <= fault_d;
    end
  end
  assign aligned       = {addr_q[ADDR_W-1:OB], {OB{1'b0}}};
  assign beat1         = state_q == B1_REQ;
  assign req_ready     = state_q == IDLE;
  assign mem_req_valid = (state_q == B0_REQ && !fault_q) || beat1;
  assign mem_addr      = !mem_req_valid ? '0 : beat1 ? aligned + ADDR_W'(NB) : aligned;
  assign mem_be        = !mem_req_valid ? '0 : beat1 ? be1 : be0;
  assign mem_wdata     = !mem_req_valid ? '0 : beat1 ? wdata1 : wdata0;
  assign mem_we        = mem_req_valid && write_q;
  assign rsp_valid     = state_q == DONE;
  assign rsp_fault     = rsp_valid && fault_q;
  assign rsp_rdata     = (rsp_valid && !fault_q && !write_q) ? ld_data : '0;
endmodule
